// File: rtl/uart_instr_assembler.sv
// uart_instr_assembler
//   Receives 8N1 UART bytes and packs every four accepted bytes, little-endian,
//   into a 32-bit instruction word. The word is delivered with a one-cycle
//   strobe once the consumer is not busy.
//
// Ports
//   clk12           in   system clock, all state on rising edge
//   rst             in   asynchronous active-high reset
//   rx              in   asynchronous UART line, idle high
//   busy            in   consumer cannot accept a word this cycle
//   instruction     out  last delivered word (valid in the strobe cycle)
//   instruction_rcv out  one-cycle delivery strobe
//   frame_err       out  sticky, a stop bit was sampled low
//   overrun         out  sticky, a completed word was dropped while one was pending
//
// Byte FSM
//   state | meaning
//   IDLE  | line idle, waiting for synchronized rx low
//   START | half-bit wait, then confirm the start bit is still low
//   DATA  | sample 8 data bits, LSB first, one bit period apart
//   STOP  | sample the stop bit, accept or reject the byte
module uart_instr_assembler #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_CLKS = 12000
) (
  input  logic        clk12,
  input  logic        rst,
  input  logic        rx,
  input  logic        busy,
  output logic [31:0] instruction,
  output logic        instruction_rcv,
  output logic        frame_err,
  output logic        overrun
);

  localparam int BCW = $clog2(CLKS_PER_BIT + 1);
  localparam int TCW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BCW-1:0] BIT_LOAD  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_LOAD = BCW'((CLKS_PER_BIT / 2) - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_sync_q;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      word_q, word_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_word_q, pend_word_d;
  logic [31:0]      instr_q, instr_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [TCW-1:0]   to_cnt_q, to_cnt_d;
  logic             deliver;
  logic             byte_ok;
  logic             byte_bad;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      instr_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      instr_q     <= instr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign deliver = pend_q & ~busy;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    instr_d     = instr_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    to_cnt_d    = to_cnt_q;
    byte_ok     = 1'b0;
    byte_bad    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d   = START;
          bit_cnt_d = HALF_LOAD;
          to_cnt_d  = '0;
        end
      end
      START: begin
        if (bit_cnt_q == '0) begin
          if (!rx_sync_q) begin
            state_d   = DATA;
            bit_cnt_d = BIT_LOAD;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt_q == '0) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = BIT_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt_q == '0) begin
          state_d  = IDLE;
          byte_ok  = rx_sync_q;
          byte_bad = ~rx_sync_q;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (deliver) begin
      pend_d  = 1'b0;
      instr_d = pend_word_q;
    end

    // A word completing while pend_q is set is dropped, so the set of pend_d
    // below can never collide with the clear on delivery above.
    if (byte_ok) begin
      unique case (byte_idx_q)
        2'd0: word_d[7:0]   = shift_q;
        2'd1: word_d[15:8]  = shift_q;
        2'd2: word_d[23:16] = shift_q;
        default: begin
          word_d = '0;
          if (pend_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_d      = 1'b1;
            pend_word_d = {shift_q, word_q};
          end
        end
      endcase
      byte_idx_d = byte_idx_q + 2'd1;
    end

    if (byte_bad) begin
      frame_err_d = 1'b1;
      byte_idx_d  = '0;
      word_d      = '0;
    end

    // Partial-word timeout only counts idle line time between bytes; a start
    // bit in IDLE restarts it above.
    if (state_q == IDLE && byte_idx_q != 2'd0 && rx_sync_q) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d   = '0;
        byte_idx_d = '0;
        word_d     = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // The word is exposed in the strobe cycle itself, before instr_q catches up.
  assign instruction_rcv = deliver;
  assign instruction     = deliver ? pend_word_q : instr_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;

endmodule
